// File: rtl/controlador_contador_pkg.sv
// Shared definitions for the round-robin counter controller:
// state encodings and the state width.
package controlador_contador_pkg;

  localparam int unsigned STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/contador_en.sv
// Shared up-counter with synchronous clear (priority over enable) and
// asynchronous active-low reset.
module contador_en #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             en,
  output logic [WIDTH-1:0] cuenta
);

  logic [WIDTH-1:0] cuenta_q;
  logic [WIDTH-1:0] cuenta_d;

  always_comb begin
    cuenta_d = cuenta_q;
    if (clr) begin
      cuenta_d = '0;
    end else if (en) begin
      cuenta_d = cuenta_q + WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cuenta_q <= '0;
    end else begin
      cuenta_q <= cuenta_d;
    end
  end

  assign cuenta = cuenta_q;

endmodule

// File: rtl/controlador_contador.sv
// Round-robin arbiter granting a shared counter to one requester at a time;
// the owner's counter runs up to its latched terminal count, then gets a done pulse.
module controlador_contador
  import controlador_contador_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned N_REQ = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ*WIDTH-1:0] limite,
  output logic [N_REQ-1:0]       grant,
  output logic [N_REQ-1:0]       done,
  output logic                   busy,
  output logic [WIDTH-1:0]       cuenta
);

  localparam int unsigned PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  state_e             state_q;
  logic [PTR_W-1:0]   ptr_q;
  logic [PTR_W-1:0]   win_q;
  logic [WIDTH-1:0]   lim_q;
  logic [N_REQ-1:0]   grant_q;
  logic [N_REQ-1:0]   done_q;
  logic               busy_q;

  logic               arb_found;
  logic [PTR_W-1:0]   arb_idx;
  logic [PTR_W-1:0]   cand;
  logic               cnt_clr;
  logic               cnt_en;

  // Search starts just after the last completed owner, wrapping modulo N_REQ.
  always_comb begin
    arb_found = 1'b0;
    arb_idx   = ptr_q;
    cand      = ptr_q;
    for (int unsigned off = 1; off <= N_REQ; off++) begin
      cand = PTR_W'((32'(ptr_q) + off) % N_REQ);
      if (!arb_found && req[cand]) begin
        arb_found = 1'b1;
        arb_idx   = cand;
      end
    end
  end

  // Counter is cleared on a new grant or an abort; it advances only while short of the limit.
  always_comb begin
    cnt_clr = 1'b0;
    cnt_en  = 1'b0;
    case (state_q)
      ST_IDLE: cnt_clr = arb_found;
      ST_RUN: begin
        if (!req[win_q]) begin
          cnt_clr = 1'b1;
        end else if (cuenta != lim_q) begin
          cnt_en = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      ptr_q   <= PTR_W'(N_REQ - 1);
      win_q   <= '0;
      lim_q   <= '0;
      grant_q <= '0;
      done_q  <= '0;
      busy_q  <= 1'b0;
    end else begin
      done_q <= '0;
      case (state_q)
        ST_IDLE: begin
          if (arb_found) begin
            state_q <= ST_RUN;
            win_q   <= arb_idx;
            lim_q   <= limite[32'(arb_idx)*WIDTH +: WIDTH];
            grant_q <= N_REQ'(1) << arb_idx;
            busy_q  <= 1'b1;
          end
        end
        ST_RUN: begin
          // An abandoned request wins over completion: no done, pointer unchanged.
          if (!req[win_q]) begin
            state_q <= ST_IDLE;
            grant_q <= '0;
            busy_q  <= 1'b0;
          end else if (cuenta == lim_q) begin
            state_q <= ST_DONE;
            grant_q <= '0;
            done_q  <= grant_q;
            busy_q  <= 1'b0;
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
          ptr_q   <= win_q;
        end
        default: begin
          state_q <= ST_IDLE;
          grant_q <= '0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  contador_en #(
    .WIDTH(WIDTH)
  ) u_contador (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (cnt_clr),
    .en    (cnt_en),
    .cuenta(cuenta)
  );

  assign grant = grant_q;
  assign done  = done_q;
  assign busy  = busy_q;

endmodule

// File: tb/tb_controlador_contador.sv
// Scoreboard bench: stimulus queues expected grant/done events with their
// cycle numbers; a negedge monitor pops and compares every observed event.
module tb_controlador_contador;

  logic        clk;
  logic        rst_n;
  logic [3:0]  req_a;
  logic [31:0] limite_a;
  logic [3:0]  grant_a;
  logic [3:0]  done_a;
  logic        busy_a;
  logic [7:0]  cuenta_a;
  logic [1:0]  req_b;
  logic [31:0] limite_b;
  logic [1:0]  grant_b;
  logic [1:0]  done_b;
  logic        busy_b;
  logic [15:0] cuenta_b;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct {
    int         dut;
    bit         is_done;
    logic [7:0] val;
    logic [15:0] cnt;
    int         cy;
  } ev_t;

  ev_t exp_q[$];
  logic [3:0] prev_grant_a = '0;
  logic [1:0] prev_grant_b = '0;

  controlador_contador #(.WIDTH(8), .N_REQ(4)) dut_a (
    .clk(clk), .rst_n(rst_n), .req(req_a), .limite(limite_a),
    .grant(grant_a), .done(done_a), .busy(busy_a), .cuenta(cuenta_a)
  );

  controlador_contador #(.WIDTH(16), .N_REQ(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .req(req_b), .limite(limite_b),
    .grant(grant_b), .done(done_b), .busy(busy_b), .cuenta(cuenta_b)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  task automatic push_ev(input int d, input bit is_done, input logic [7:0] v,
                         input logic [15:0] cnt, input int cy);
    ev_t e;
    e.dut = d; e.is_done = is_done; e.val = v; e.cnt = cnt; e.cy = cy;
    exp_q.push_back(e);
  endtask

  task automatic observe(input int d, input bit is_done, input logic [7:0] v,
                         input logic [15:0] cnt);
    ev_t e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL unexpected_event: dut%0d %s=%b cuenta=%h at cycle %0d, none expected",
               d, is_done ? "done" : "grant", v, cnt, cyc);
      return;
    end
    e = exp_q.pop_front();
    if (e.dut != d || e.is_done != is_done || e.val != v || e.cy != cyc ||
        (is_done && e.cnt != cnt)) begin
      errors++;
      $display("FAIL event: got dut%0d %s=%b cuenta=%h cycle %0d, expected dut%0d %s=%b cuenta=%h cycle %0d",
               d, is_done ? "done" : "grant", v, cnt, cyc,
               e.dut, e.is_done ? "done" : "grant", e.val, e.cnt, e.cy);
    end
  endtask

  // Monitor: a done pulse or a newly raised grant is an output event.
  always @(negedge clk) begin
    if (done_a != '0) observe(0, 1'b1, 8'(done_a), 16'(cuenta_a));
    if (grant_a != '0 && grant_a != prev_grant_a) observe(0, 1'b0, 8'(grant_a), 16'd0);
    prev_grant_a = grant_a;
    if (done_b != '0) observe(1, 1'b1, 8'(done_b), cuenta_b);
    if (grant_b != '0 && grant_b != prev_grant_b) observe(1, 1'b0, 8'(grant_b), 16'd0);
    prev_grant_b = grant_b;
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset;
    @(negedge clk);
    rst_n = 1'b0;
    req_a = '0;
    req_b = '0;
    step(2);
    chk("rst_grant_a", 32'(grant_a), 32'd0);
    chk("rst_done_a", 32'(done_a), 32'd0);
    chk("rst_busy_a", 32'(busy_a), 32'd0);
    chk("rst_cuenta_a", 32'(cuenta_a), 32'd0);
    chk("rst_cuenta_b", 32'(cuenta_b), 32'd0);
    rst_n = 1'b1;
  endtask

  initial begin
    int c;
    int r;
    rst_n = 1'b0;
    req_a = '0;
    req_b = '0;
    limite_a = '0;
    limite_b = '0;
    do_reset();

    // Single requester 0, limit 3; limit change mid-run must be ignored.
    @(negedge clk);
    c = cyc;
    limite_a = {8'd0, 8'd0, 8'd0, 8'd3};
    req_a = 4'b0001;
    push_ev(0, 1'b0, 8'b0001, 16'd0, c + 1);
    push_ev(0, 1'b1, 8'b0001, 16'd3, c + 5);
    step(1);
    chk("t34_cuenta0", 32'(cuenta_a), 32'd0);
    chk("t34_busy", 32'(busy_a), 32'd1);
    step(1);
    chk("t34_cuenta1", 32'(cuenta_a), 32'd1);
    limite_a[7:0] = 8'd7;
    step(1);
    chk("t34_cuenta2", 32'(cuenta_a), 32'd2);
    step(1);
    chk("t34_cuenta3", 32'(cuenta_a), 32'd3);
    step(1);
    chk("t34_grant_in_done", 32'(grant_a), 32'd0);
    chk("t34_busy_in_done", 32'(busy_a), 32'd0);
    req_a = '0;
    step(2);
    chk("t34_grant_after", 32'(grant_a), 32'd0);

    // Limit 0 on requester 2: one RUN cycle, done right after.
    @(negedge clk);
    c = cyc;
    limite_a[23:16] = 8'd0;
    req_a = 4'b0100;
    push_ev(0, 1'b0, 8'b0100, 16'd0, c + 1);
    push_ev(0, 1'b1, 8'b0100, 16'd0, c + 2);
    step(1);
    chk("t36_busy_run", 32'(busy_a), 32'd1);
    step(1);
    chk("t36_busy_done", 32'(busy_a), 32'd0);
    req_a = '0;
    step(2);

    // All requesters held, limit 1: grants rotate 0,1,2,3,0 every 4 cycles.
    do_reset();
    @(negedge clk);
    c = cyc;
    limite_a = {4{8'd1}};
    req_a = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      push_ev(0, 1'b0, 8'(1 << (i % 4)), 16'd0, c + 1 + 4 * i);
      push_ev(0, 1'b1, 8'(1 << (i % 4)), 16'd1, c + 3 + 4 * i);
    end
    step(19);
    req_a = '0;
    step(3);

    // Requester 1 (limit 10) abandons at cuenta=4; pending requester 2 is served next.
    do_reset();
    @(negedge clk);
    c = cyc;
    limite_a = {8'd0, 8'd1, 8'd10, 8'd0};
    req_a = 4'b0110;
    push_ev(0, 1'b0, 8'b0010, 16'd0, c + 1);
    step(5);
    chk("t37_cuenta4", 32'(cuenta_a), 32'd4);
    req_a = 4'b0100;
    step(1);
    chk("t37_abort_cuenta", 32'(cuenta_a), 32'd0);
    chk("t37_abort_grant", 32'(grant_a), 32'd0);
    chk("t37_abort_busy", 32'(busy_a), 32'd0);
    push_ev(0, 1'b0, 8'b0100, 16'd0, c + 7);
    push_ev(0, 1'b1, 8'b0100, 16'd1, c + 9);
    step(3);
    req_a = '0;
    step(2);

    // Reset at cuenta=5 clears everything at once; requester 0 then wins first.
    @(negedge clk);
    c = cyc;
    limite_a[7:0] = 8'd10;
    req_a = 4'b0001;
    push_ev(0, 1'b0, 8'b0001, 16'd0, c + 1);
    step(6);
    chk("t39_cuenta5", 32'(cuenta_a), 32'd5);
    rst_n = 1'b0;
    #1;
    chk("t39_rst_grant", 32'(grant_a), 32'd0);
    chk("t39_rst_done", 32'(done_a), 32'd0);
    chk("t39_rst_busy", 32'(busy_a), 32'd0);
    chk("t39_rst_cuenta", 32'(cuenta_a), 32'd0);
    step(1);
    limite_a = {4{8'd1}};
    req_a = 4'b1111;
    rst_n = 1'b1;
    r = cyc;
    push_ev(0, 1'b0, 8'b0001, 16'd0, r + 1);
    push_ev(0, 1'b1, 8'b0001, 16'd1, r + 3);
    step(3);
    req_a = '0;
    step(3);

    // 16-bit instance at full-scale limit: reaches FFFF, no wrap, then done.
    @(negedge clk);
    c = cyc;
    limite_b = {16'd0, 16'hFFFF};
    req_b = 2'b01;
    push_ev(1, 1'b0, 8'b01, 16'd0, c + 1);
    push_ev(1, 1'b1, 8'b01, 16'hFFFF, c + 65537);
    step(65536);
    chk("t38_cuenta_max", 32'(cuenta_b), 32'h0000FFFF);
    chk("t38_busy", 32'(busy_b), 32'd1);
    step(1);
    chk("t38_cuenta_hold", 32'(cuenta_b), 32'h0000FFFF);
    req_b = '0;
    step(3);

    while (exp_q.size() > 0) begin
      ev_t e;
      e = exp_q.pop_front();
      checks++;
      errors++;
      $display("FAIL missing_event: dut%0d %s=%b expected at cycle %0d never seen",
               e.dut, e.is_done ? "done" : "grant", e.val, e.cy);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/controlador_contador.md
CONTROLADOR_CONTADOR -- requirements
Module: controlador_contador

Interface
REQ-001 Parameter WIDTH, default 8: bit width of the shared counter and of each terminal count.
REQ-002 Parameter N_REQ, default 4: number of requesters, range 2..8.
REQ-003 The block SHALL have exactly one clock; reset is asynchronous and active-low.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 req  input  N_REQ  per-requester level request; held high until done or abandoned.
REQ-007 limite  input  N_REQ*WIDTH  packed terminal counts; slice i = limite[i*WIDTH +: WIDTH].
REQ-008 grant  output  N_REQ  one-hot owner of the counter; all-zero when idle.
REQ-009 done  output  N_REQ  one-cycle completion pulse to the owner.
REQ-010 busy  output  1  high while in state RUN.
REQ-011 cuenta  output  WIDTH  current shared counter value.

Function
REQ-012 FSM states: IDLE, RUN, DONE; encoding is binary, 2 bits.
REQ-013 IDLE: if req != 0, choose the winner round-robin, starting at index ptr+1 mod N_REQ; next state RUN. Otherwise stay in IDLE.
REQ-014 On the IDLE->RUN edge: grant = one-hot(winner); the winner's limite slice is latched into lim_q; the counter is cleared to 0.
REQ-015 Later changes to limite SHALL NOT affect a run in progress.
REQ-016 RUN: the counter increments by 1 each cycle while cuenta != lim_q.
REQ-017 RUN: when cuenta == lim_q, next state is DONE and the counter holds.
REQ-018 DONE: done[winner] = 1 for exactly this cycle and grant = 0; ptr <= winner; next state IDLE.
REQ-019 Latency: req seen in IDLE at edge t gives grant at t+1, cuenta = k at t+1+k, and done at t+2+lim_q.
REQ-020 lim_q = 0: RUN lasts one cycle and done follows at t+2.
REQ-021 lim_q = 2^WIDTH-1: the count reaches the maximum value with no wrap; arithmetic is modulo 2^WIDTH, but wrap is unreachable.
REQ-022 Abort: if req[winner] falls during RUN, the next state is IDLE and the counter clears. No done is produced and ptr is not updated.
REQ-023 A new request is not arbitrated in the DONE cycle; the earliest re-grant comes one cycle after DONE.
REQ-024 Requests arriving during RUN or DONE are held by the requesters and are not lost.
REQ-025 With all req high, grants SHALL rotate 0,1,2,...,N_REQ-1,0.
REQ-026 grant and done SHALL always be one-hot or zero; done and grant are never high together.
REQ-027 busy = (state == RUN).

Reset
REQ-028 rst_n low SHALL asynchronously force: state IDLE, cuenta 0, lim_q 0, grant 0, done 0, busy 0, and ptr = N_REQ-1, so that requester 0 wins first.
REQ-029 Reset asserted mid-RUN or mid-DONE SHALL abort with no done pulse.
REQ-030 After reset release, the first arbitration occurs at the first clk edge with rst_n high.

Structure
REQ-031 The FSM state encodings (ST_IDLE, ST_RUN, ST_DONE) and the state width constant SHALL live in a shared package/header used by RTL and bench.
REQ-032 The counter SHALL be one sub-module, contador_en: parameter WIDTH; inputs clk, rst_n, clr (synchronous), en; output cuenta.
REQ-033 The round-robin arbiter and the FSM stay in controlador_contador. Target size is 120-400 RTL lines.

Verification
REQ-034 Reset then req=4'b0001, limite slice0=3: grant=0001 at t+1; cuenta 0,1,2,3; done=0001 at t+5; then grant=0000.
REQ-035 req=4'b1111 held, all limits 1: grants 0001,0010,0100,1000,0001 in order, each followed by a one-cycle done.
REQ-036 Limit 0 on requester 2 alone: grant at t+1, done=0100 at t+2, busy high for one cycle.
REQ-037 Requester 1 running (limit 10) drops req at cuenta=4: next cycle IDLE, cuenta=0, no done. Requester 2, pending, is granted afterwards.
REQ-038 WIDTH=16 instance, limit 16'hFFFF: cuenta reaches FFFF without wrap, then done.
REQ-039 rst_n pulsed low mid-RUN at cuenta=5: grant, done, busy, and cuenta are all 0 immediately. After release, requester 0 wins first.
